// File: rtl/rv_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes,
// the LSU state type, fault codes and small funct3 decode helpers.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_FUNCT3   = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // Unsigned sizes only exist for loads; stores accept B/H/W.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return ~is_store;
      default:          return 1'b0;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a bus word and extends it.
module load_align
  import rv_pkg::*;
#(
  parameter int DATA_LENGTH = 32
) (
  input  logic [DATA_LENGTH-1:0] rdata,
  input  logic [1:0]             offset,
  input  logic [2:0]             funct3,
  output logic [DATA_LENGTH-1:0] load_data
);

  logic [DATA_LENGTH-1:0] shifted;
  logic [7:0]             lane_b;
  logic [15:0]            lane_h;

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by size.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    case (funct3)
      F3_B:    load_data = {{(DATA_LENGTH-8){lane_b[7]}}, lane_b};
      F3_H:    load_data = {{(DATA_LENGTH-16){lane_h[15]}}, lane_h};
      F3_BU:   load_data = {{(DATA_LENGTH-8){1'b0}}, lane_b};
      F3_HU:   load_data = {{(DATA_LENGTH-16){1'b0}}, lane_h};
      F3_W:    load_data = rdata;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit. One bus access at a time: IDLE accepts a
// legal aligned memory op and stalls the pipe, BUSY holds the request until
// ack or timeout, DONE releases the stall and pulses writeback. Illegal or
// misaligned ops never reach the bus; they only raise a one-cycle fault.
module lsu_mem
  import rv_pkg::*;
#(
  parameter int DATA_LENGTH = 32,
  parameter int TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   mem_read_in,
  input  logic                   mem_write_in,
  input  logic [2:0]             funct3_in,
  input  logic [DATA_LENGTH-1:0] addr_in,
  input  logic [DATA_LENGTH-1:0] wdata_in,
  input  logic [4:0]             rd_in,
  output logic                   stall_out,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DATA_LENGTH-1:0] dmem_addr,
  output logic [3:0]             dmem_be,
  output logic [DATA_LENGTH-1:0] dmem_wdata,
  input  logic [DATA_LENGTH-1:0] dmem_rdata,
  input  logic                   dmem_ack,
  output logic [DATA_LENGTH-1:0] load_data_out,
  output logic [4:0]             rd_out,
  output logic                   wb_valid_out,
  output logic [1:0]             fault_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t             state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   mem_op, op_legal, op_misal, accept, timeout_hit;
  logic [3:0]             be_nxt;
  logic [DATA_LENGTH-1:0] wdata_nxt;
  logic [2:0]             funct3_p1;
  logic [1:0]             offset_p1;
  logic [DATA_LENGTH-1:0] load_fmt;

  load_align #(.DATA_LENGTH(DATA_LENGTH)) u_load_align (
    .rdata     (dmem_rdata),
    .offset    (offset_p1),
    .funct3    (funct3_p1),
    .load_data (load_fmt)
  );

  // Store lane enables and lane-replicated write data for the incoming op.
  always_comb begin
    case (funct3_in)
      F3_B, F3_BU: begin
        be_nxt    = 4'b0001 << addr_in[1:0];
        wdata_nxt = {(DATA_LENGTH/8){wdata_in[7:0]}};
      end
      F3_H, F3_HU: begin
        be_nxt    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {(DATA_LENGTH/16){wdata_in[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = wdata_in;
      end
    endcase
  end

  // Decode, next state and stall. The timeout cycle drops stall so the
  // faulting op retires instead of being re-accepted from a held slot.
  always_comb begin
    mem_op      = valid_in & (mem_read_in | mem_write_in);
    op_legal    = f3_legal(funct3_in, mem_write_in);
    op_misal    = f3_misaligned(funct3_in, addr_in[1:0]);
    accept      = mem_op & op_legal & ~op_misal;
    timeout_hit = ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));
    state_nxt   = state;
    stall_out   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall_out = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_out = ~timeout_hit;
        if (dmem_ack)         state_nxt = DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!rst) stall_out = 1'b0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Bus request, writeback and fault outputs plus the BUSY cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt           <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_be       <= 4'b0000;
      dmem_wdata    <= '0;
      load_data_out <= '0;
      rd_out        <= 5'd0;
      wb_valid_out  <= 1'b0;
      fault_out     <= FAULT_NONE;
    end else begin
      wb_valid_out <= 1'b0;
      fault_out    <= FAULT_NONE;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (mem_op && !op_legal) begin
            fault_out <= FAULT_FUNCT3;
          end else if (mem_op && op_misal) begin
            fault_out <= FAULT_MISALIGN;
          end else if (accept) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_in;
            dmem_addr  <= {addr_in[DATA_LENGTH-1:2], 2'b00};
            dmem_be    <= be_nxt;
            dmem_wdata <= wdata_nxt;
            rd_out     <= rd_in;
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            wb_valid_out  <= 1'b1;
            load_data_out <= dmem_we ? '0 : load_fmt;
          end else if (timeout_hit) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            fault_out <= FAULT_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Size and lane offset of the accepted op, consumed by load_align on ack.
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      funct3_p1 <= funct3_in;
      offset_p1 <= addr_in[1:0];
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Bench for lsu_mem: directed vector table, hand-written reset and
// stray-ack sequences, then randomized ops against a reference model.
module tb_lsu_mem;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, mem_read_in, mem_write_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, wdata_in;
  logic [4:0]  rd_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] load_data_out;
  logic [4:0]  rd_out;
  logic        wb_valid_out;
  logic [1:0]  fault_out;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem #(.DATA_LENGTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .funct3_in(funct3_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .rd_in(rd_in), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .load_data_out(load_data_out), .rd_out(rd_out),
    .wb_valid_out(wb_valid_out), .fault_out(fault_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fault;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] ldata;
  } exp_t;

  typedef struct {
    int          req_cycles;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  fault;
    int          nfault;
    int          nwb;
    int          wb_at;
    logic [31:0] ldata;
    logic [4:0]  rdo;
    logic        stall0;
    logic        stall_any;
  } obs_t;

  typedef struct {
    logic [2:0]  f3;
    logic        st;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdw;
    int          dly;
    logic [4:0]  rd;
    logic [1:0]  fault;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] ldata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: behaviour derived from sizes, offsets and masks.
  function automatic exp_t model(input logic [2:0] f3, input logic st,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdw);
    exp_t e;
    int size, off;
    logic [31:0] mask, v;
    e = '{fault: 2'd0, be: 4'd0, wdata: 32'd0, addr: 32'd0, ldata: 32'd0};
    off  = int'(a[1:0]);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.addr = a - 32'(off);
    if (f3 == 3'b011 || f3[2:1] == 2'b11 || (st && f3[2])) e.fault = 2'd2;
    else if (off % size != 0) e.fault = 2'd1;
    mask    = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    e.be    = 4'(((1 << size) - 1) << off);
    e.wdata = (size == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
              (size == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    v = (rdw >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && (v & ((mask >> 1) + 32'd1)) != 32'd0) v = v | ~mask;
    e.ldata = st ? 32'd0 : v;
    return e;
  endfunction

  // Present one op, play the bus slave (ack on BUSY cycle dly, never if
  // dly<0, random stray acks otherwise) and record what the DUT did.
  task automatic run_op(input logic [2:0] f3, input logic st, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdw, input int dly,
                        input logic [4:0] rd, output obs_t o);
    int  busy_idx, ncyc;
    logic drop;
    o = '{default: 0};
    valid_in = 1'b1; mem_read_in = ~st; mem_write_in = st;
    funct3_in = f3; addr_in = a; wdata_in = wd; rd_in = rd;
    dmem_ack = 1'b0;
    #1;
    o.stall0 = stall_out;
    o.stall_any = stall_out;
    drop = ~stall_out;
    ncyc = (dly < 0) ? TIMEOUT + 4 : dly + 5;
    busy_idx = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      if (drop) begin
        #1;
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        drop = 1'b0;
      end
      @(negedge clk);
      if (stall_out) o.stall_any = 1'b1;
      if (valid_in && !stall_out) drop = 1'b1;
      if (dmem_req) begin
        if (o.req_cycles == 0) begin
          o.be = dmem_be; o.wdata = dmem_wdata; o.addr = dmem_addr; o.we = dmem_we;
        end
        o.req_cycles++;
        dmem_ack   = (busy_idx == dly);
        dmem_rdata = (busy_idx == dly) ? rdw : $urandom;
        busy_idx++;
      end else begin
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      if (wb_valid_out) begin
        o.nwb++; o.wb_at = c; o.ldata = load_data_out; o.rdo = rd_out;
      end
      if (fault_out != 2'd0) begin
        o.nfault++; o.fault = fault_out;
      end
    end
    dmem_ack = 1'b0;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
  endtask

  task automatic check_op(input string tag, input exp_t e, input logic st, input int dly,
                          input logic [4:0] rd, input obs_t o);
    if (e.fault != 2'd0) begin
      chk({tag, ".fault"}, 32'(o.fault), 32'(e.fault));
      chk({tag, ".nfault"}, 32'(o.nfault), 32'd1);
      chk({tag, ".req_cycles"}, 32'(o.req_cycles), 32'd0);
      chk({tag, ".nwb"}, 32'(o.nwb), 32'd0);
      chk({tag, ".stall"}, 32'(o.stall_any), 32'd0);
    end else if (dly < 0) begin
      chk({tag, ".req_cycles"}, 32'(o.req_cycles), 32'(TIMEOUT));
      chk({tag, ".fault"}, 32'(o.fault), 32'd3);
      chk({tag, ".nfault"}, 32'(o.nfault), 32'd1);
      chk({tag, ".nwb"}, 32'(o.nwb), 32'd0);
      chk({tag, ".addr"}, o.addr, e.addr);
    end else begin
      chk({tag, ".stall0"}, 32'(o.stall0), 32'd1);
      chk({tag, ".req_cycles"}, 32'(o.req_cycles), 32'(dly + 1));
      chk({tag, ".addr"}, o.addr, e.addr);
      chk({tag, ".we"}, 32'(o.we), 32'(st));
      if (st) begin
        chk({tag, ".be"}, 32'(o.be), 32'(e.be));
        chk({tag, ".wdata"}, o.wdata, e.wdata);
      end
      chk({tag, ".nwb"}, 32'(o.nwb), 32'd1);
      chk({tag, ".wb_at"}, 32'(o.wb_at), 32'(dly + 2));
      chk({tag, ".ldata"}, o.ldata, e.ldata);
      chk({tag, ".rd"}, 32'(o.rdo), 32'(rd));
      chk({tag, ".nfault"}, 32'(o.nfault), 32'd0);
    end
  endtask

  initial begin
    vec_t vec[16];
    obs_t o;
    exp_t e;

    vec[0]  = '{3'b000, 1'b0, 32'h103, 32'h0,        32'h80FF_0000, 0,  5'd5,  2'd0, 4'b1000, 32'h0,         32'h100, 32'hFFFF_FF80};
    vec[1]  = '{3'b001, 1'b1, 32'h202, 32'h0000_BEEF, 32'h0,        1,  5'd6,  2'd0, 4'b1100, 32'hBEEF_BEEF, 32'h200, 32'h0};
    vec[2]  = '{3'b010, 1'b0, 32'h101, 32'h0,        32'h0,         0,  5'd7,  2'd1, 4'b0000, 32'h0,         32'h100, 32'h0};
    vec[3]  = '{3'b101, 1'b0, 32'h102, 32'h0,        32'h0,         -1, 5'd8,  2'd0, 4'b1100, 32'h0,         32'h100, 32'h0};
    vec[4]  = '{3'b100, 1'b0, 32'h103, 32'h0,        32'h80FF_0000, 2,  5'd9,  2'd0, 4'b1000, 32'h0,         32'h100, 32'h0000_0080};
    vec[5]  = '{3'b001, 1'b0, 32'h102, 32'h0,        32'h80FF_0000, 0,  5'd10, 2'd0, 4'b1100, 32'h0,         32'h100, 32'hFFFF_80FF};
    vec[6]  = '{3'b101, 1'b0, 32'h100, 32'h0,        32'h1234_F00D, 1,  5'd11, 2'd0, 4'b0011, 32'h0,         32'h100, 32'h0000_F00D};
    vec[7]  = '{3'b010, 1'b0, 32'h104, 32'h0,        32'h1234_5678, 3,  5'd12, 2'd0, 4'b1111, 32'h0,         32'h104, 32'h1234_5678};
    vec[8]  = '{3'b000, 1'b1, 32'h101, 32'h1234_56A5, 32'h0,        0,  5'd13, 2'd0, 4'b0010, 32'hA5A5_A5A5, 32'h100, 32'h0};
    vec[9]  = '{3'b010, 1'b1, 32'h10C, 32'hDEAD_BEEF, 32'h0,        4,  5'd14, 2'd0, 4'b1111, 32'hDEAD_BEEF, 32'h10C, 32'h0};
    vec[10] = '{3'b011, 1'b0, 32'h100, 32'h0,        32'h0,         0,  5'd15, 2'd2, 4'b0000, 32'h0,         32'h100, 32'h0};
    vec[11] = '{3'b100, 1'b1, 32'h100, 32'h0,        32'h0,         0,  5'd16, 2'd2, 4'b0000, 32'h0,         32'h100, 32'h0};
    vec[12] = '{3'b001, 1'b1, 32'h201, 32'h0,        32'h0,         0,  5'd17, 2'd1, 4'b0000, 32'h0,         32'h200, 32'h0};
    vec[13] = '{3'b001, 1'b0, 32'h005, 32'h0,        32'h0,         0,  5'd18, 2'd1, 4'b0000, 32'h0,         32'h004, 32'h0};
    vec[14] = '{3'b010, 1'b1, 32'h106, 32'h0,        32'h0,         0,  5'd19, 2'd1, 4'b0000, 32'h0,         32'h104, 32'h0};
    vec[15] = '{3'b000, 1'b0, 32'h001, 32'h0,        32'h0000_7F00, 1,  5'd20, 2'd0, 4'b0010, 32'h0,         32'h000, 32'h0000_007F};

    rst = 1'b0;
    valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    funct3_in = 3'b000; addr_in = 32'h0; wdata_in = 32'h0; rd_in = 5'd0;
    dmem_rdata = 32'h0; dmem_ack = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst.stall", 32'(stall_out), 32'd0);
    chk("rst.req", 32'(dmem_req), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    chk("rst.be", 32'(dmem_be), 32'd0);
    chk("rst.addr", dmem_addr, 32'd0);
    chk("rst.wdata", dmem_wdata, 32'd0);
    chk("rst.ldata", load_data_out, 32'd0);
    chk("rst.rd", 32'(rd_out), 32'd0);
    chk("rst.wb", 32'(wb_valid_out), 32'd0);
    chk("rst.fault", 32'(fault_out), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 16; i++) begin
      e = '{fault: vec[i].fault, be: vec[i].be, wdata: vec[i].wdata,
            addr: vec[i].addr, ldata: vec[i].ldata};
      run_op(vec[i].f3, vec[i].st, vec[i].a, vec[i].wd, vec[i].rdw, vec[i].dly, vec[i].rd, o);
      check_op($sformatf("vec%0d", i), e, vec[i].st, vec[i].dly, vec[i].rd, o);
    end

    // Reset asserted in the second BUSY cycle.
    @(negedge clk);
    valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0;
    funct3_in = 3'b010; addr_in = 32'h300; rd_in = 5'd9; dmem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstbusy.req_c1", 32'(dmem_req), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstbusy.req_async", 32'(dmem_req), 32'd0);
    chk("rstbusy.stall", 32'(stall_out), 32'd0);
    chk("rstbusy.wb", 32'(wb_valid_out), 32'd0);
    valid_in = 1'b0; mem_read_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstbusy.req_after", 32'(dmem_req), 32'd0);
    chk("rstbusy.wb_after", 32'(wb_valid_out), 32'd0);

    // Stray ack while idle must not produce a writeback.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stray.wb", 32'(wb_valid_out), 32'd0);
    chk("stray.req", 32'(dmem_req), 32'd0);

    // Fresh word load after the aborted access returns data unchanged.
    e = model(3'b010, 1'b0, 32'h100, 32'h0, 32'h1234_5678);
    run_op(3'b010, 1'b0, 32'h100, 32'h0, 32'h1234_5678, 0, 5'd3, o);
    check_op("postrst", e, 1'b0, 0, 5'd3, o);

    // Randomized ops against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  f3;
      logic        st;
      logic [31:0] a, wd, rdw;
      logic [4:0]  rd;
      int          dly;
      f3  = 3'($urandom_range(0, 7));
      st  = 1'($urandom_range(0, 1));
      a   = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      wd  = $urandom;
      rdw = $urandom;
      rd  = 5'($urandom_range(0, 31));
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      e = model(f3, st, a, wd, rdw);
      run_op(f3, st, a, wd, rdw, dly, rd, o);
      check_op($sformatf("rnd%0d", i), e, st, dly, rd, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
